// File: rtl/icache_sa_if.sv
// CPU fetch port and memory refill port of the set-associative instruction cache.
// The cache takes the slave view; the core/memory side takes the master view.
interface icache_sa_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic [ADDR_W-1:0] cpu_adr;
   logic              cpu_req;
   logic [DATA_W-1:0] cpu_instr;
   logic              hit;
   logic              abort;
   logic              flush;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_adr;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_val;
   logic [31:0]       hit_cnt;
   logic [31:0]       miss_cnt;

   modport slave (
      input  cpu_adr, cpu_req, flush, mem_rdata, mem_val,
      output cpu_instr, hit, abort, mem_req, mem_adr, hit_cnt, miss_cnt
   );

   modport master (
      output cpu_adr, cpu_req, flush, mem_rdata, mem_val,
      input  cpu_instr, hit, abort, mem_req, mem_adr, hit_cnt, miss_cnt
   );
endinterface

// File: rtl/icache_sa.sv
// Set-associative instruction cache: combinational lookup, in-order multi-word line refill,
// round-robin replacement, set-by-set flush and saturating hit/miss counters.
module icache_sa #(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned WAYS       = 2,
   parameter int unsigned SETS       = 16,
   parameter int unsigned LINE_WORDS = 4
) (
   input logic        clk,
   input logic        reset,
   icache_sa_if.slave bus
);
   localparam int unsigned OFF_B = $clog2(LINE_WORDS);
   localparam int unsigned IDX_B = $clog2(SETS);
   localparam int unsigned WAY_B = $clog2(WAYS);
   localparam int unsigned CNT_W = (OFF_B > 0) ? OFF_B : 1;
   localparam int unsigned WAY_W = (WAY_B > 0) ? WAY_B : 1;
   localparam int unsigned TAG_W = ADDR_W - 2 - OFF_B - IDX_B;
   localparam logic [CNT_W-1:0] OFF_MASK = CNT_W'(LINE_WORDS - 1);

   typedef enum logic [1:0] {StIdle, StRefill, StFlush} state_e;

   state_e              state_q, state_d;
   logic [TAG_W-1:0]    tag_q;
   logic [IDX_B-1:0]    idx_q, fcnt_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [WAY_W-1:0]    victim_q;
   logic                by_ptr_q, pend_q, mem_req_q;
   logic [ADDR_W-1:0]   mem_adr_q;
   logic [31:0]         hit_cnt_q, miss_cnt_q;

   logic [WAYS-1:0]     valid_q  [SETS];
   logic [WAY_W-1:0]    ptr_q    [SETS];
   logic [TAG_W-1:0]    tag_mem  [SETS][WAYS];
   logic [DATA_W-1:0]   data_mem [SETS][WAYS][LINE_WORDS];

   logic [CNT_W-1:0]    a_off;
   logic [IDX_B-1:0]    a_idx;
   logic [TAG_W-1:0]    a_tag;
   logic                match, lookup_hit, free_found;
   logic [WAY_W-1:0]    hit_way, free_way;
   logic                start_miss, fill_we, fill_last, flush_clr;

   function automatic logic [ADDR_W-1:0] word_adr(logic [TAG_W-1:0] t, logic [IDX_B-1:0] i,
                                                  logic [CNT_W-1:0] c);
      word_adr = (ADDR_W'(t) << (2 + OFF_B + IDX_B)) | (ADDR_W'(i) << (2 + OFF_B)) |
                 (ADDR_W'(c & OFF_MASK) << 2);
   endfunction

   assign a_off = CNT_W'(bus.cpu_adr >> 2) & OFF_MASK;
   assign a_idx = IDX_B'(bus.cpu_adr >> (2 + OFF_B));
   assign a_tag = TAG_W'(bus.cpu_adr >> (2 + OFF_B + IDX_B));

   always_comb begin
      match      = 1'b0;
      hit_way    = '0;
      free_found = 1'b0;
      free_way   = '0;
      for (int w = 0; w < int'(WAYS); w++) begin
         if (valid_q[a_idx][w] && tag_mem[a_idx][w] == a_tag) begin
            match   = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
      // Descending scan so the lowest-index invalid way wins.
      for (int w = int'(WAYS) - 1; w >= 0; w--) begin
         if (!valid_q[a_idx][w]) begin
            free_found = 1'b1;
            free_way   = WAY_W'(w);
         end
      end
   end

   assign lookup_hit    = bus.cpu_req & (state_q == StIdle) & match;
   assign bus.hit       = lookup_hit;
   assign bus.abort     = bus.cpu_req & ~lookup_hit;
   assign bus.cpu_instr = lookup_hit ? data_mem[a_idx][hit_way][a_off] : '0;
   assign bus.mem_req   = mem_req_q;
   assign bus.mem_adr   = mem_adr_q;
   assign bus.hit_cnt   = hit_cnt_q;
   assign bus.miss_cnt  = miss_cnt_q;

   always_comb begin
      state_d    = state_q;
      start_miss = 1'b0;
      fill_we    = 1'b0;
      fill_last  = 1'b0;
      flush_clr  = 1'b0;
      case (state_q)
         StIdle: begin
            if (pend_q || bus.flush) begin
               state_d = StFlush;
            end else if (bus.cpu_req && !lookup_hit) begin
               state_d    = StRefill;
               start_miss = 1'b1;
            end
         end
         StRefill: begin
            if (bus.mem_val) begin
               fill_we = 1'b1;
               if (cnt_q == OFF_MASK) begin
                  fill_last = 1'b1;
                  state_d   = StIdle;
               end
            end
         end
         StFlush: begin
            flush_clr = 1'b1;
            if (fcnt_q == IDX_B'(SETS - 1)) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         tag_q      <= '0;
         idx_q      <= '0;
         fcnt_q     <= '0;
         cnt_q      <= '0;
         victim_q   <= '0;
         by_ptr_q   <= 1'b0;
         pend_q     <= 1'b0;
         mem_req_q  <= 1'b0;
         mem_adr_q  <= '0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
         valid_q    <= '{default: '0};
         ptr_q      <= '{default: '0};
      end else begin
         state_q <= state_d;
         if (start_miss) begin
            tag_q     <= a_tag;
            idx_q     <= a_idx;
            cnt_q     <= '0;
            victim_q  <= free_found ? free_way : ptr_q[a_idx];
            by_ptr_q  <= ~free_found;
            mem_req_q <= 1'b1;
            mem_adr_q <= word_adr(a_tag, a_idx, '0);
            if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
         end
         if (fill_we) begin
            cnt_q     <= cnt_q + CNT_W'(1);
            mem_adr_q <= word_adr(tag_q, idx_q, cnt_q + CNT_W'(1));
         end
         if (fill_last) begin
            mem_req_q               <= 1'b0;
            valid_q[idx_q][victim_q] <= 1'b1;
            if (by_ptr_q) begin
               ptr_q[idx_q] <= (ptr_q[idx_q] == WAY_W'(WAYS - 1)) ? '0
                                                                   : ptr_q[idx_q] + WAY_W'(1);
            end
         end
         if (state_q == StRefill && bus.flush) pend_q <= 1'b1;
         if (state_q == StIdle && state_d == StFlush) begin
            pend_q <= 1'b0;
            fcnt_q <= '0;
         end
         if (flush_clr) begin
            valid_q[fcnt_q] <= '0;
            ptr_q[fcnt_q]   <= '0;
            fcnt_q          <= fcnt_q + IDX_B'(1);
         end
         if (lookup_hit && hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
      end
   end

   // Line contents survive reset and flush; only valid bits gate their use.
   always_ff @(posedge clk) begin
      if (fill_we) data_mem[idx_q][victim_q][cnt_q] <= bus.mem_rdata;
      if (fill_last) tag_mem[idx_q][victim_q] <= tag_q;
   end
endmodule

// File: tb/tb_icache_sa.sv
// Directed bench for icache_sa: 2 ways, 16 sets, 4-word lines, memory answering one cycle
// after each address with data = address ^ 32'hA5A5_0000.
module tb_icache_sa;
   logic        clk = 1'b0;
   logic        reset;
   int          checks = 0;
   int          errors = 0;
   logic        mv = 1'b0;
   logic [31:0] mdata = '0;
   logic        stray_val;
   logic [31:0] stray_data;
   bit          seen = 1'b0;
   logic [31:0] log_q[$];

   always #5 clk = ~clk;

   icache_sa_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   icache_sa #(
      .ADDR_W(32), .DATA_W(32), .WAYS(2), .SETS(16), .LINE_WORDS(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   assign bus.mem_val   = mv | stray_val;
   assign bus.mem_rdata = stray_val ? stray_data : mdata;

   // Memory model: mem_val one cycle after each new address, held for one cycle.
   always @(negedge clk) begin
      if (mv) begin
         mv   = 1'b0;
         seen = bus.mem_req;
      end else if (bus.mem_req) begin
         if (seen) begin
            mv    = 1'b1;
            mdata = bus.mem_adr ^ 32'hA5A5_0000;
            log_q.push_back(bus.mem_adr);
            seen  = 1'b0;
         end else begin
            seen = 1'b1;
         end
      end else begin
         seen = 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Holds a request until hit; exp_wait counts stalled cycles before the hit cycle.
   task automatic req_wait(input logic [31:0] a, input bit first_hit, input int exp_wait,
                           input int flush_at);
      int n;
      n = 0;
      bus.cpu_adr = a;
      bus.cpu_req = 1'b1;
      bus.flush   = 1'b0;
      #1;
      chk("first_hit", bus.hit, first_hit);
      chk("abort", bus.abort, !first_hit);
      if (first_hit) chk("no_mem_req", bus.mem_req, 1'b0);
      while (!bus.hit && n < 60) begin
         @(negedge clk);
         #1;
         n++;
         bus.flush = (n == flush_at);
         #1;
         if (n == 1 && !first_hit && exp_wait == 9) chk("mem_req_rise", bus.mem_req, 1'b1);
      end
      chk("wait", n, exp_wait);
      chk("instr", bus.cpu_instr, a ^ 32'hA5A5_0000);
      @(negedge clk);
      #1;
      bus.cpu_req = 1'b0;
      bus.flush   = 1'b0;
   endtask

   initial begin
      reset       = 1'b1;
      stray_val   = 1'b0;
      stray_data  = '0;
      bus.cpu_req = 1'b1;
      bus.cpu_adr = 32'h10;
      bus.flush   = 1'b0;
      #1 reset = 1'b0;
      @(negedge clk);
      #1;
      chk("rst_hit", bus.hit, 1'b0);
      chk("rst_instr", bus.cpu_instr, 32'h0);
      chk("rst_abort", bus.abort, 1'b1);
      chk("rst_mem_req", bus.mem_req, 1'b0);
      chk("rst_mem_adr", bus.mem_adr, 32'h0);
      chk("rst_hit_cnt", bus.hit_cnt, 32'd0);
      chk("rst_miss_cnt", bus.miss_cnt, 32'd0);
      bus.cpu_req = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      #1;

      // 1: cold miss, in-order line refill, then hit
      log_q.delete();
      req_wait(32'h10, 1'b0, 9, -1);
      chk("t1_words", log_q.size(), 32'd4);
      for (int i = 0; i < 4 && i < log_q.size(); i++) chk("t1_adr", log_q[i], 32'h10 + 4 * i);
      chk("t1_miss", bus.miss_cnt, 32'd1);
      chk("t1_hit", bus.hit_cnt, 32'd1);

      // 2: rest of the line hits back-to-back
      log_q.delete();
      req_wait(32'h14, 1'b1, 0, -1);
      req_wait(32'h18, 1'b1, 0, -1);
      req_wait(32'h1C, 1'b1, 0, -1);
      chk("t2_hit", bus.hit_cnt, 32'd4);
      chk("t2_words", log_q.size(), 32'd0);
      chk("t2_mem_req", bus.mem_req, 1'b0);

      // 3: conflicts in set 0, round-robin victim
      req_wait(32'h000, 1'b0, 9, -1);
      req_wait(32'h100, 1'b0, 9, -1);
      req_wait(32'h200, 1'b0, 9, -1);
      req_wait(32'h100, 1'b1, 0, -1);
      req_wait(32'h000, 1'b0, 9, -1);
      req_wait(32'h200, 1'b1, 0, -1);
      chk("t3_miss", bus.miss_cnt, 32'd5);
      chk("t3_hit", bus.hit_cnt, 32'd10);

      // 4: flush in idle blocks 16 cycles, then the line misses
      bus.flush = 1'b1;
      @(negedge clk);
      #1;
      bus.flush = 1'b0;
      req_wait(32'h10, 1'b0, 25, -1);
      chk("t4_miss", bus.miss_cnt, 32'd6);
      chk("t4_hit", bus.hit_cnt, 32'd11);

      // 5: flush during word 2 of a refill; refill completes, then flush
      log_q.delete();
      req_wait(32'h20, 1'b0, 9, 3);
      chk("t5_words", log_q.size(), 32'd4);
      req_wait(32'h20, 1'b0, 25, -1);
      chk("t5_miss", bus.miss_cnt, 32'd8);
      chk("t5_hit", bus.hit_cnt, 32'd13);

      // 6: reset mid-refill, then a stray mem_val
      bus.cpu_adr = 32'h30;
      bus.cpu_req = 1'b1;
      repeat (3) begin
         @(negedge clk);
         #1;
      end
      reset = 1'b0;
      #1;
      chk("t6_mem_req", bus.mem_req, 1'b0);
      chk("t6_mem_adr", bus.mem_adr, 32'h0);
      chk("t6_miss", bus.miss_cnt, 32'd0);
      chk("t6_hit", bus.hit_cnt, 32'd0);
      @(negedge clk);
      #1;
      reset = 1'b1;
      bus.cpu_req = 1'b0;
      @(negedge clk);
      #1;
      stray_data = 32'hDEAD_BEEF;
      stray_val  = 1'b1;
      @(negedge clk);
      #1;
      stray_val = 1'b0;
      #1;
      chk("t6_stray_req", bus.mem_req, 1'b0);
      chk("t6_stray_miss", bus.miss_cnt, 32'd0);
      chk("t6_stray_hit", bus.hit_cnt, 32'd0);
      req_wait(32'h30, 1'b0, 9, -1);
      chk("t6_after_miss", bus.miss_cnt, 32'd1);
      chk("t6_after_hit", bus.hit_cnt, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
